// File: rtl/demux_stream.sv
// demux_stream: registered 1:N stream demultiplexer with valid/ready on the
// input and on every output channel. Each channel owns a one-entry holding
// register that presents its word until the consumer takes it.
// Optional broadcast mode is compiled in with `define DEMUX_BCAST_EN; without
// it the in_bcast port is present but ignored and all words are unicast.

module demux_stream #(
   parameter int W = 8,
   parameter int N = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   in_data,
   input  logic [SW-1:0]  in_sel,
   input  logic           in_bcast,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [N*W-1:0] out_data,
   output logic [N-1:0]   out_valid,
   input  logic [N-1:0]   out_ready,
   output logic           err_sel
);

   logic [N-1:0] free;
   logic [N-1:0] load;
   logic         sel_ok;
   logic         free_sel;
   logic         bcast_act;
   logic         xfer;
   logic         err_next;

`ifdef DEMUX_BCAST_EN
   assign bcast_act = in_bcast;
`else
   logic bcast_unused;
   assign bcast_unused = in_bcast;
   assign bcast_act    = 1'b0;
`endif

   // Channel freedom, select decode, handshake and per-channel load strobes.
   // A channel draining this cycle counts as free so a stream never bubbles.
   // Selects beyond N-1 are accepted and dropped so the producer cannot stall.
   always_comb begin
      free     = ~out_valid | out_ready;
      sel_ok   = 1'b0;
      free_sel = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (32'(in_sel) == k) begin
            sel_ok   = 1'b1;
            free_sel = free[k];
         end
      end

      if (bcast_act)
         in_ready = &free;
      else if (sel_ok)
         in_ready = free_sel;
      else
         in_ready = 1'b1;

      xfer     = in_valid && in_ready;
      err_next = xfer && !bcast_act && !sel_ok;

      load = '0;
      for (int k = 0; k < N; k++)
         load[k] = xfer && (bcast_act || (32'(in_sel) == k));
   end

   // Holding registers: load wins over drain; a drained channel keeps its data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= '0;
         out_data  <= '0;
         err_sel   <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (load[k]) begin
               out_data[k*W +: W] <= in_data;
               out_valid[k]       <= 1'b1;
            end else if (out_ready[k]) begin
               out_valid[k]       <= 1'b0;
            end
         end
         err_sel <= err_next;
      end
   end

endmodule
